// File: rtl/wave_pkg.sv
// Shared types and constants for the ADC waveform measurement front end.
package wave_pkg;

  localparam int ADC_W = 8;
  localparam int unsigned GATE_CLKS_50M = 50_000_000;
  localparam logic [ADC_W-1:0] MID_RESET = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/adc_wave_meas_cross_det.sv
// Hysteresis comparator with a persistent LO/HI level and a rising-crossing pulse.
module cross_det
  import wave_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_en,
  input  logic [ADC_W-1:0] i_sample,
  input  logic [ADC_W-1:0] i_thr_hi,
  input  logic [ADC_W-1:0] i_thr_lo,
  output logic             o_rise
);

  logic r_level;
  logic w_go_hi;
  logic w_go_lo;

  // The pulse is combinational so a crossing on the final gate sample still counts.
  assign w_go_hi = i_en && !r_level && (i_sample >= i_thr_hi);
  assign w_go_lo = i_en && r_level && (i_sample <= i_thr_lo);
  assign o_rise  = w_go_hi;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_level <= 1'b0;
    end else if (w_go_hi) begin
      r_level <= 1'b1;
    end else if (w_go_lo) begin
      r_level <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_wave_meas.sv
// Gated frequency / max / min measurement of the ADC stream, published once per window.
// Optional last-period timer enabled by defining ADC_WAVE_MEAS_PERIOD_EN.
module adc_wave_meas
  import wave_pkg::*;
#(
  parameter int unsigned GATE_CLKS = GATE_CLKS_50M,
  parameter int unsigned HYST      = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             meas_en,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic [31:0]      freq_cnt,
  output logic [ADC_W-1:0] vmax,
  output logic [ADC_W-1:0] vmin,
  output logic             no_sig,
  output logic [31:0]      period_clks,
  output logic             meas_valid
);

  localparam logic [ADC_W:0] HYST_W    = HYST[ADC_W:0];
  localparam logic [31:0]    GATE_LAST = 32'(GATE_CLKS - 1);

  function automatic logic [ADC_W-1:0] f_thr_hi(input logic [ADC_W-1:0] mid);
    logic [ADC_W:0] s;
    s = {1'b0, mid} + HYST_W;
    return (s > {1'b0, {ADC_W{1'b1}}}) ? {ADC_W{1'b1}} : s[ADC_W-1:0];
  endfunction

  function automatic logic [ADC_W-1:0] f_thr_lo(input logic [ADC_W-1:0] mid);
    logic [ADC_W:0] s;
    s = {1'b0, mid} - HYST_W;
    return ({1'b0, mid} < HYST_W) ? '0 : s[ADC_W-1:0];
  endfunction

  function automatic logic [31:0] f_sat_inc(input logic [31:0] x);
    return (x == '1) ? x : x + 32'd1;
  endfunction

  function automatic logic [ADC_W-1:0] f_mid(input logic [ADC_W-1:0] hi,
                                             input logic [ADC_W-1:0] lo);
    logic [ADC_W:0] s;
    s = {1'b0, hi} + {1'b0, lo};
    return s[ADC_W:1];
  endfunction

  state_e           r_state;
  logic [31:0]      r_gate_cnt;
  logic [31:0]      r_cross_cnt;
  logic             r_seen;
  logic [ADC_W-1:0] r_max;
  logic [ADC_W-1:0] r_min;
  logic [ADC_W-1:0] r_mid;
  logic [31:0]      r_freq;
  logic [ADC_W-1:0] r_vmax;
  logic [ADC_W-1:0] r_vmin;
  logic             r_no_sig;
  logic             r_meas_valid;

  logic             w_in_gate;
  logic             w_smp;
  logic             w_rise;
  logic             w_start;
  logic             w_latch;
  logic             w_seen_nxt;
  logic [ADC_W-1:0] w_max_nxt;
  logic [ADC_W-1:0] w_min_nxt;
  logic [31:0]      w_cnt_nxt;

  assign w_in_gate  = (r_state == ST_GATE);
  assign w_smp      = w_in_gate && adc_valid;
  assign w_start    = (r_state == ST_IDLE || r_state == ST_LATCH) && meas_en;
  assign w_latch    = w_in_gate && meas_en && (r_gate_cnt == GATE_LAST);
  assign w_seen_nxt = r_seen | w_smp;
  assign w_max_nxt  = (w_smp && adc_data > r_max) ? adc_data : r_max;
  assign w_min_nxt  = (w_smp && adc_data < r_min) ? adc_data : r_min;
  assign w_cnt_nxt  = w_rise ? f_sat_inc(r_cross_cnt) : r_cross_cnt;

  cross_det u_cross_det (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .i_en     (w_smp),
    .i_sample (adc_data),
    .i_thr_hi (f_thr_hi(r_mid)),
    .i_thr_lo (f_thr_lo(r_mid)),
    .o_rise   (w_rise)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_gate_cnt   <= '0;
      r_cross_cnt  <= '0;
      r_seen       <= 1'b0;
      r_max        <= '0;
      r_min        <= '1;
      r_mid        <= MID_RESET;
      r_freq       <= '0;
      r_vmax       <= '0;
      r_vmin       <= '0;
      r_no_sig     <= 1'b0;
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_start) begin
        r_state     <= ST_GATE;
        r_gate_cnt  <= '0;
        r_cross_cnt <= '0;
        r_seen      <= 1'b0;
        r_max       <= '0;
        r_min       <= '1;
      end else if (r_state == ST_GATE) begin
        if (!meas_en) begin
          r_state <= ST_IDLE;
        end else begin
          r_gate_cnt  <= r_gate_cnt + 32'd1;
          r_cross_cnt <= w_cnt_nxt;
          r_seen      <= w_seen_nxt;
          r_max       <= w_max_nxt;
          r_min       <= w_min_nxt;
          if (w_latch) begin
            r_state      <= ST_LATCH;
            r_meas_valid <= 1'b1;
            r_freq       <= w_cnt_nxt;
            r_no_sig     <= !w_seen_nxt;
            r_vmax       <= w_seen_nxt ? w_max_nxt : '0;
            r_vmin       <= w_seen_nxt ? w_min_nxt : '0;
            if (w_seen_nxt) begin
              r_mid <= f_mid(w_max_nxt, w_min_nxt);
            end
          end
        end
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

`ifdef ADC_WAVE_MEAS_PERIOD_EN
  logic [31:0] r_timer;
  logic [31:0] r_hold;
  logic        r_had_rise;
  logic [31:0] r_period;

  // Timer restarts at 1 so the captured value equals the crossing spacing in cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_timer    <= '0;
      r_hold     <= '0;
      r_had_rise <= 1'b0;
      r_period   <= '0;
    end else begin
      if (w_rise) begin
        r_timer    <= 32'd1;
        r_had_rise <= 1'b1;
        if (r_had_rise) begin
          r_hold <= r_timer;
        end
      end else begin
        r_timer <= f_sat_inc(r_timer);
      end
      if (w_latch) begin
        r_period <= (w_rise && r_had_rise) ? r_timer : r_hold;
      end
    end
  end

  assign period_clks = r_period;
`else
  assign period_clks = '0;
`endif

  assign freq_cnt   = r_freq;
  assign vmax       = r_vmax;
  assign vmin       = r_vmin;
  assign no_sig     = r_no_sig;
  assign meas_valid = r_meas_valid;

endmodule
